banco_filtros_mux: RTL

//  Parametrised successor to the fixed three-band IIR filter stage. BANDS parallel bands, each a

---
 rtl/banco_filtros_mux.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/banco_filtros_mux.sv
// banco_filtros_mux: BANDS parallel bands, each a cascade of STAGES direct-form-I biquads,
// all evaluated sequentially on one shared multiplier-accumulator. Coefficients live in a
// small register file that can be rewritten at runtime while the engine is idle.
//
// Ports:
//   clock_In    system clock, rising edge
//   Reset       synchronous reset, active high
//   enable      sample strobe; starts a frame when sampled high while idle
//   Data_In     input sample (signed 1.Magnitud.Decimal), captured with enable
//   coef_we     coefficient write strobe (honoured only while idle)
//   coef_addr   ((band*STAGES+stage)*5+k), k: 0=b0 1=b1 2=b2 3=a1 4=a2
//   coef_data   coefficient value, same format as samples
//   Data_Out    band b result at [b*N +: N]; all bands update together at frame end
//   Data_Valid  one-cycle pulse when Data_Out is updated
//   busy        high while a frame is in progress (including the final DONE cycle)
//   sat         sticky clip flag for the current frame, cleared at frame start
//   err         one-cycle pulse when enable/coef_we is ignored or coef_addr is out of range
module banco_filtros_mux #(
  parameter int unsigned N        = 25,
  parameter int unsigned Magnitud = 8,
  parameter int unsigned Decimal  = 16,
  parameter int unsigned BANDS    = 3,
  parameter int unsigned STAGES   = 2,
  localparam int unsigned AW      = $clog2(BANDS * STAGES * 5)
) (
  input  logic               clock_In,
  input  logic               Reset,
  input  logic               enable,
  input  logic [N-1:0]       Data_In,
  input  logic               coef_we,
  input  logic [AW-1:0]      coef_addr,
  input  logic [N-1:0]       coef_data,
  output logic [BANDS*N-1:0] Data_Out,
  output logic               Data_Valid,
  output logic               busy,
  output logic               sat,
  output logic               err
);

  localparam int unsigned NBQ   = BANDS * STAGES;
  localparam int unsigned NCOEF = NBQ * 5;
  localparam int unsigned BW    = (NBQ > 1) ? $clog2(NBQ) : 1;
  localparam int unsigned SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned BNW   = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int unsigned AccW  = 2 * N + 3;

  localparam logic [N-1:0] CoefOne = N'(1) << Decimal;
  localparam logic signed [AccW-1:0] SatMax = {{(AccW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW-N+1){1'b1}}, {(N-1){1'b0}}};

  if (N != 1 + Magnitud + Decimal) begin : g_bad_width
    $error("N must equal 1 + Magnitud + Decimal");
  end

  typedef enum logic [1:0] {StIdle, StMac, StWb, StDone} state_e;

  state_e state_q, state_d;
  logic   start, mac_en, wb_en;

  logic [2:0]     k_q;
  logic [BW-1:0]  bq_q;
  logic [SW-1:0]  stage_q;
  logic [BNW-1:0] band_q;
  logic           last_bq, last_stage;

  logic signed [N-1:0] coef_q     [NCOEF];
  logic signed [N-1:0] x1_q       [NBQ];
  logic signed [N-1:0] x2_q       [NBQ];
  logic signed [N-1:0] y1_q       [NBQ];
  logic signed [N-1:0] y2_q       [NBQ];
  logic signed [N-1:0] band_res_q [BANDS];
  logic signed [N-1:0] x_in_q, cur_x_q;

  logic [AW-1:0]          coef_idx;
  logic signed [N-1:0]    coef_sel, op_sel, res;
  logic signed [2*N-1:0]  prod;
  logic [AccW-1:0]        prod_ext;
  logic signed [AccW-1:0] acc_q, acc_d, shifted;
  logic                   clip;
  logic                   addr_ok, coef_wr;

  logic [BANDS*N-1:0] data_out_q;
  logic               valid_q, sat_q, err_q;

  assign busy       = (state_q != StIdle);
  assign last_bq    = (bq_q == BW'(NBQ - 1));
  assign last_stage = (stage_q == SW'(STAGES - 1));
  assign addr_ok    = (32'(coef_addr) < NCOEF);
  assign coef_wr    = coef_we & ~busy & addr_ok;

  assign Data_Out   = data_out_q;
  assign Data_Valid = valid_q;
  assign sat        = sat_q;
  assign err        = err_q;

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock_In) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    mac_en  = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          start   = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (k_q == 3'd4) state_d = StWb;
      end
      StWb: begin
        wb_en   = 1'b1;
        state_d = last_bq ? StDone : StMac;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Shared MAC: one product per MAC cycle, k selects coefficient and history operand
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    coef_idx = AW'(32'(bq_q) * 5 + 32'(k_q));
    coef_sel = coef_q[coef_idx];
    op_sel   = '0;
    case (k_q)
      3'd0:    op_sel = cur_x_q;
      3'd1:    op_sel = x1_q[bq_q];
      3'd2:    op_sel = x2_q[bq_q];
      3'd3:    op_sel = y1_q[bq_q];
      3'd4:    op_sel = y2_q[bq_q];
      default: op_sel = '0;
    endcase
    prod     = coef_sel * op_sel;
    prod_ext = {{3{prod[2*N-1]}}, prod};
    // k=0 starts a fresh accumulation; feedback terms (a1, a2) are subtracted
    acc_d = (k_q == 3'd0) ? '0 : acc_q;
    if (k_q >= 3'd3) acc_d = acc_d - prod_ext;
    else             acc_d = acc_d + prod_ext;
  end

  // Result: arithmetic shift back to sample scale (truncating), then clip to N bits
  always_comb begin
    shifted = acc_q >>> Decimal;
    clip    = 1'b0;
    if (shifted > SatMax) begin
      res  = SatMax[N-1:0];
      clip = 1'b1;
    end else if (shifted < SatMin) begin
      res  = SatMin[N-1:0];
      clip = 1'b1;
    end else begin
      res = shifted[N-1:0];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock_In) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NCOEF; i++) begin
        coef_q[i] <= (i % 5 == 0) ? CoefOne : '0;
      end
      for (int unsigned i = 0; i < NBQ; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      for (int unsigned i = 0; i < BANDS; i++) begin
        band_res_q[i] <= '0;
      end
      x_in_q     <= '0;
      cur_x_q    <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      bq_q       <= '0;
      stage_q    <= '0;
      band_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= (busy & (enable | coef_we)) | (~busy & coef_we & ~addr_ok);

      if (coef_wr) coef_q[coef_addr] <= coef_data;

      if (start) begin
        x_in_q  <= Data_In;
        cur_x_q <= Data_In;
        k_q     <= '0;
        bq_q    <= '0;
        stage_q <= '0;
        band_q  <= '0;
        sat_q   <= 1'b0;
      end

      if (mac_en) begin
        acc_q <= acc_d;
        k_q   <= (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
      end

      if (wb_en) begin
        x1_q[bq_q] <= cur_x_q;
        x2_q[bq_q] <= x1_q[bq_q];
        y1_q[bq_q] <= res;
        y2_q[bq_q] <= y1_q[bq_q];
        if (clip) sat_q <= 1'b1;

        if (last_stage) begin
          // Band finished: park its result, next band restarts from the frame's input sample
          band_res_q[band_q] <= res;
          cur_x_q            <= x_in_q;
          stage_q            <= '0;
          band_q             <= last_bq ? '0 : band_q + BNW'(1);
        end else begin
          cur_x_q <= res;
          stage_q <= stage_q + SW'(1);
        end
        bq_q <= last_bq ? '0 : bq_q + BW'(1);

        if (last_bq) begin
          for (int unsigned b = 0; b < BANDS; b++) begin
            data_out_q[b*N +: N] <= (BNW'(b) == band_q) ? res : band_res_q[b];
          end
          valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
